sic1_cpu: RTL and testbench
===========================

Name: sic1_cpu

Overview:
SUBLEQ execution sequencer for SIC-1; sits directly upstream of sic1_memory and drives its address, write and byte-select inputs. Each instruction is three bytes A, B, C: mem[A] <= mem[A] - mem[B]; if the signed 8-bit result <= 0, jump to C, else PC += 3. It consumes the memory's instruction-field and byte outputs. I/O at 253/254 is handled entirely by sic1_memory.

Parameters:
RESET_PC, 8'd0, PC value loaded on reset.
HALT_ADDR, 8'd255, PC value that stops execution.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
run  in  1  start/continue execution; sampled only in FETCH
wr_en  out  1  memory write strobe
wr_addr  out  8  byte address written (A)
wr_byte  out  8  byte written (mem[A]-mem[B])
ra_addr  out  6  memory port A word address
rb_addr  out  6  memory port B word address
PC_low  out  2  PC[1:0], selects instruction byte alignment
out_A  in  8  instruction byte 0 from memory
out_B  in  8  instruction byte 1
out_C  in  8  instruction byte 2
rb_byte_idx  out  2  byte lane selected on port B
rb_byte  in  8  selected port-B byte (input-mapped at 253)
pc  out  8  current program counter
halted  out  1  sticky; PC reached HALT_ADDR
inst_done  out  1  one-cycle pulse per retired instruction

Behaviour:
- Memory contract: read data appears the cycle after its address is presented. A write must occur while ra_addr holds, and was already presenting in the preceding cycle, the word containing wr_addr.
- Reset (rst_n=0 at clk edge): state=FETCH, pc=RESET_PC, halted=0, wr_en=0, inst_done=0, latched A/B/C/a_val/b_val=0. Reset mid-instruction aborts it; no write is issued.
- FETCH: ra_addr=pc[7:2], rb_addr=pc[7:2]+1 (mod 64, wraps 63->0), PC_low=pc[1:0]. Go to DECODE if run=1 and halted=0, else stay.
- DECODE: latch A=out_A, B=out_B, C=out_C. Drive ra_addr=out_A[7:2], rb_addr=out_A[7:2], rb_byte_idx=out_A[1:0]. Go to LOAD_A.
- LOAD_A: a_val<=rb_byte. ra_addr=A[7:2] (held), rb_addr=B[7:2], rb_byte_idx=B[1:0]. Go to LOAD_B.
- LOAD_B: b_val<=rb_byte. ra_addr=A[7:2] held. Go to EXEC.
- EXEC: wr_en=1, wr_addr=A, wr_byte=a_val-b_val (8-bit wrap), ra_addr=A[7:2]. leq = diff[7] | (diff==0). next_pc = leq ? C : pc+3 (mod 256). pc<=next_pc, inst_done=1, halted<=(next_pc==HALT_ADDR), state->FETCH.
- wr_en and inst_done are high only in EXEC. wr_addr/wr_byte are don't-care elsewhere but driven 0.
- Latency: 5 cycles per instruction (FETCH..EXEC), back-to-back when run is held.
- run deasserted mid-instruction: the instruction completes; the CPU idles in FETCH.
- halted: sticky until reset; FETCH stays idle regardless of run.
- A==B: both reads return the same byte, the result is 0, and the branch is taken.
- A=253 (input): a_val=ui_in via rb_byte; the write goes to the memory word as normal.
- A=254: write produces output strobe in sic1_memory.
- PC at 253..254: fetch wraps across word 63->0. Not an error.
- Branch target C=255: halts. pc+3 landing on 255 (pc=252) also halts.

Decomposition:
- Package sic1_pkg: state enum (FETCH, DECODE, LOAD_A, LOAD_B, EXEC), ADDR_MAX=252, ADDR_IN=253, ADDR_OUT=254, HALT_ADDR=255; shared with sic1_memory.
- One natural sub-module: sic1_alu (combinational), with inputs a, b and outputs diff[7:0], leq. The FSM stays in sic1_cpu.

Test Plan:
- Reset then run=1, mem[0..2]={3,4,9}, mem[3]=5, mem[4]=2: mem[3]=3, no branch, pc=3 after 5 cycles, inst_done pulses once.
- mem[0..2]={3,4,9}, mem[3]=2, mem[4]=5: mem[3]=0xFD (negative), branch taken, pc=9.
- A==B: {3,3,12} with mem[3]=0x7F: mem[3]=0, pc=12.
- Output path: {254,5,255} with mem[254]=0, mem[5]=0xF6: uo_out=0x0A with out_strobe pulse; pc=255; halted=1; run held high -> no further wr_en.
- Input path: {8,253,...} with ui_in=0x07: mem[8] decremented by 7.
- Assert rst_n=0 during LOAD_B: no wr_en, pc=0, state FETCH. Drop run mid-instruction: that instruction retires, then idle with wr_en=0.

Source files
------------

// File: rtl/sic1_pkg.sv
// Shared SIC-1 constants: FSM state codes and the special byte addresses.
package sic1_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned WORD_ADDR_W = 6;
    localparam int unsigned STATE_W     = 3;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_LOAD_A = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;

    localparam logic [7:0] ADDR_MAX  = 8'd252;
    localparam logic [7:0] ADDR_IN   = 8'd253;
    localparam logic [7:0] ADDR_OUT  = 8'd254;
    localparam logic [7:0] HALT_ADDR = 8'd255;

endpackage

// File: rtl/sic1_alu.sv
// SUBLEQ arithmetic: 8-bit wrapping difference and the signed "<= 0" branch test.
module sic1_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff,
    output logic       leq
);

    assign diff = 8'(a - b);
    assign leq  = diff[7] | (diff == 8'd0);

endmodule

// File: rtl/sic1_cpu.sv
// SIC-1 SUBLEQ sequencer: FETCH, DECODE, LOAD_A, LOAD_B, EXEC per instruction,
// steering the two read ports and the write port of sic1_memory.
module sic1_cpu #(
    parameter logic [7:0] RESET_PC  = 8'd0,
    parameter logic [7:0] HALT_ADDR = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_byte,
    output logic [5:0] ra_addr,
    output logic [5:0] rb_addr,
    output logic [1:0] PC_low,
    input  logic [7:0] out_A,
    input  logic [7:0] out_B,
    input  logic [7:0] out_C,
    output logic [1:0] rb_byte_idx,
    input  logic [7:0] rb_byte,
    output logic [7:0] pc,
    output logic       halted,
    output logic       inst_done
);

    import sic1_pkg::*;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  c_q;
    logic [DATA_W-1:0]  a_val;
    logic [DATA_W-1:0]  b_val;
    logic [DATA_W-1:0]  diff;
    logic               leq;
    logic [DATA_W-1:0]  next_pc;

    sic1_alu u_alu (
        .a    (a_val),
        .b    (b_val),
        .diff (diff),
        .leq  (leq)
    );

    assign next_pc = leq ? c_q : 8'(pc + 8'd3);
    assign PC_low  = pc[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Instruction operands, fetched values, PC and halt flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            a_val  <= '0;
            b_val  <= '0;
        end else begin
            case (state)
                S_DECODE: begin
                    a_q <= out_A;
                    b_q <= out_B;
                    c_q <= out_C;
                end
                S_LOAD_A: a_val <= rb_byte;
                S_LOAD_B: b_val <= rb_byte;
                S_EXEC: begin
                    pc     <= next_pc;
                    halted <= (next_pc == HALT_ADDR);
                end
                default: ;
            endcase
        end
    end

    // Next state and memory-port steering; port A keeps A's word from DECODE on
    // so the EXEC write lands on a word that was already being presented.
    always_comb begin
        state_nx    = state;
        ra_addr     = pc[7:2];
        rb_addr     = 6'(pc[7:2] + 6'd1);
        rb_byte_idx = 2'd0;
        wr_en       = 1'b0;
        wr_addr     = 8'd0;
        wr_byte     = 8'd0;
        inst_done   = 1'b0;

        case (state)
            S_FETCH: begin
                if (run && !halted) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                ra_addr     = out_A[7:2];
                rb_addr     = out_A[7:2];
                rb_byte_idx = out_A[1:0];
                state_nx    = S_LOAD_A;
            end
            S_LOAD_A: begin
                ra_addr     = a_q[7:2];
                rb_addr     = b_q[7:2];
                rb_byte_idx = b_q[1:0];
                state_nx    = S_LOAD_B;
            end
            S_LOAD_B: begin
                ra_addr     = a_q[7:2];
                rb_addr     = b_q[7:2];
                rb_byte_idx = b_q[1:0];
                state_nx    = S_EXEC;
            end
            S_EXEC: begin
                ra_addr     = a_q[7:2];
                rb_addr     = b_q[7:2];
                rb_byte_idx = b_q[1:0];
                wr_en       = 1'b1;
                wr_addr     = a_q;
                wr_byte     = diff;
                inst_done   = 1'b1;
                state_nx    = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_sic1_cpu.sv
// Directed bench for sic1_cpu with a small behavioural model of sic1_memory.
module tb_sic1_cpu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_byte;
    logic [5:0] ra_addr;
    logic [5:0] rb_addr;
    logic [1:0] PC_low;
    logic [7:0] out_A;
    logic [7:0] out_B;
    logic [7:0] out_C;
    logic [1:0] rb_byte_idx;
    logic [7:0] rb_byte;
    logic [7:0] pc;
    logic       halted;
    logic       inst_done;

    sic1_cpu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_byte     (wr_byte),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .PC_low      (PC_low),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_C       (out_C),
        .rb_byte_idx (rb_byte_idx),
        .rb_byte     (rb_byte),
        .pc          (pc),
        .halted      (halted),
        .inst_done   (inst_done)
    );

    always #5 clk = ~clk;

    // Memory model: registered addresses, byte 253 reads ui_in, writes to 254 strobe uo_out
    logic [7:0] mem [256];
    logic [5:0] ra_q = '0;
    logic [5:0] rb_q = '0;
    logic [1:0] pcl_q = '0;
    logic [1:0] idx_q = '0;
    logic [7:0] ui_in;
    logic [7:0] uo_out = '0;
    logic       out_strobe = 1'b0;
    logic       mem_clr;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] fb [3];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_byte;
        end
        if (wr_en && wr_addr == 8'd254) uo_out <= wr_byte;
        out_strobe <= wr_en && (wr_addr == 8'd254);
        ra_q  <= ra_addr;
        rb_q  <= rb_addr;
        pcl_q <= PC_low;
        idx_q <= rb_byte_idx;
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            logic [2:0] lane;
            lane  = 3'(pcl_q) + 3'(i);
            fb[i] = lane[2] ? mem[{rb_q, lane[1:0]}] : mem[{ra_q, lane[1:0]}];
        end
    end

    assign out_A   = fb[0];
    assign out_B   = fb[1];
    assign out_C   = fb[2];
    assign rb_byte = ({rb_q, idx_q} == 8'd253) ? ui_in : mem[{rb_q, idx_q}];

    int wr_cnt = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;

    always @(posedge clk) begin
        if (wr_en) wr_cnt++;
        if (inst_done) done_cnt++;
        if (out_strobe) strobe_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        run     = 1'b0;
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!inst_done && cyc < 20);
        check({tag, " inst_done seen"}, 32'(inst_done), 32'd1);
    endtask

    int cyc;
    int wr0;
    int done0;
    int st0;

    initial begin
        rst_n   = 1'b0;
        run     = 1'b0;
        ui_in   = 8'd0;
        ld_en   = 1'b0;
        ld_addr = 8'd0;
        ld_data = 8'd0;
        mem_clr = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst pc", 32'(pc), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst inst_done", 32'(inst_done), 32'd0);
        check("rst ra_addr", 32'(ra_addr), 32'd0);
        check("rst rb_addr", 32'(rb_addr), 32'd1);

        // Positive result: 5-2=3, fall through
        do_reset();
        poke(0, 3); poke(1, 4); poke(2, 9); poke(3, 5); poke(4, 2);
        release_reset();
        wr0 = wr_cnt; done0 = done_cnt;
        run = 1'b1;
        wait_done("t1", cyc);
        check("t1 latency", 32'(cyc), 32'd4);
        check("t1 wr_addr", 32'(wr_addr), 32'd3);
        check("t1 wr_byte", 32'(wr_byte), 32'd3);
        run = 1'b0;
        @(negedge clk);
        check("t1 mem3", 32'(mem[3]), 32'd3);
        check("t1 pc", 32'(pc), 32'd3);
        check("t1 done pulses", 32'(done_cnt - done0), 32'd1);
        check("t1 writes", 32'(wr_cnt - wr0), 32'd1);
        check("t1 inst_done low", 32'(inst_done), 32'd0);

        // Negative result: 2-5=0xFD, branch to 9
        do_reset();
        poke(0, 3); poke(1, 4); poke(2, 9); poke(3, 2); poke(4, 5);
        release_reset();
        run = 1'b1;
        wait_done("t2", cyc);
        run = 1'b0;
        @(negedge clk);
        check("t2 mem3", 32'(mem[3]), 32'hFD);
        check("t2 pc", 32'(pc), 32'd9);

        // A==B gives zero, branch taken
        do_reset();
        poke(0, 3); poke(1, 3); poke(2, 12); poke(3, 8'h7F);
        release_reset();
        run = 1'b1;
        wait_done("t3", cyc);
        run = 1'b0;
        @(negedge clk);
        check("t3 mem3", 32'(mem[3]), 32'd0);
        check("t3 pc", 32'(pc), 32'd12);

        // Output write: 0-0x0A=0xF6 branches to 255 and halts; run stays high
        do_reset();
        poke(0, 254); poke(1, 5); poke(2, 255); poke(5, 8'h0A); poke(254, 0);
        release_reset();
        wr0 = wr_cnt; st0 = strobe_cnt;
        run = 1'b1;
        wait_done("t4", cyc);
        @(negedge clk);
        check("t4 pc", 32'(pc), 32'd255);
        check("t4 halted", 32'(halted), 32'd1);
        repeat (10) @(negedge clk);
        check("t4 uo_out", 32'(uo_out), 32'hF6);
        check("t4 strobes", 32'(strobe_cnt - st0), 32'd1);
        check("t4 writes after halt", 32'(wr_cnt - wr0), 32'd1);
        check("t4 pc held", 32'(pc), 32'd255);
        check("t4 halted sticky", 32'(halted), 32'd1);
        run = 1'b0;

        // Input read: mem[8]=20 minus ui_in=7
        do_reset();
        check("t5 halted cleared", 32'(halted), 32'd0);
        poke(0, 8); poke(1, 253); poke(2, 0); poke(8, 20);
        ui_in = 8'd7;
        release_reset();
        run = 1'b1;
        wait_done("t5", cyc);
        run = 1'b0;
        @(negedge clk);
        check("t5 mem8", 32'(mem[8]), 32'd13);
        check("t5 pc", 32'(pc), 32'd3);
        ui_in = 8'd0;

        // Branch to 252, then pc+3 reaches 255 and halts, back-to-back
        do_reset();
        poke(0, 12); poke(1, 12); poke(2, 252);
        poke(252, 10); poke(253, 11); poke(254, 0);
        poke(10, 5); poke(11, 1); poke(12, 9);
        release_reset();
        run = 1'b1;
        wait_done("t6a", cyc);
        @(negedge clk);
        check("t6 pc 252", 32'(pc), 32'd252);
        check("t6 mem12", 32'(mem[12]), 32'd0);
        wait_done("t6b", cyc);
        check("t6 back-to-back latency", 32'(cyc), 32'd4);
        @(negedge clk);
        check("t6 mem10", 32'(mem[10]), 32'd4);
        check("t6 pc 255", 32'(pc), 32'd255);
        check("t6 halted", 32'(halted), 32'd1);
        run = 1'b0;

        // Fetch at 254 spans word 63 and word 0
        do_reset();
        poke(0, 12); poke(1, 12); poke(2, 254);
        poke(254, 13); poke(255, 14);
        poke(12, 7); poke(13, 1); poke(14, 1);
        release_reset();
        run = 1'b1;
        wait_done("t7a", cyc);
        @(negedge clk);
        check("t7 pc 254", 32'(pc), 32'd254);
        check("t7 rb wrap", 32'(rb_addr), 32'd0);
        wait_done("t7b", cyc);
        run = 1'b0;
        @(negedge clk);
        check("t7 mem13", 32'(mem[13]), 32'd0);
        check("t7 pc", 32'(pc), 32'd12);

        // Reset during LOAD_B aborts without writing
        do_reset();
        poke(0, 3); poke(1, 4); poke(2, 9); poke(3, 5); poke(4, 2);
        release_reset();
        wr0 = wr_cnt; done0 = done_cnt;
        run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        @(negedge clk);
        check("t8 writes", 32'(wr_cnt - wr0), 32'd0);
        check("t8 done", 32'(done_cnt - done0), 32'd0);
        check("t8 pc", 32'(pc), 32'd0);
        check("t8 ra fetch", 32'(ra_addr), 32'd0);
        check("t8 rb fetch", 32'(rb_addr), 32'd1);
        check("t8 mem3", 32'(mem[3]), 32'd5);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t8 idle pc", 32'(pc), 32'd0);

        // Drop run in DECODE: instruction retires, then idle
        do_reset();
        poke(0, 3); poke(1, 4); poke(2, 9); poke(3, 5); poke(4, 2);
        release_reset();
        wr0 = wr_cnt; done0 = done_cnt;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_done("t9", cyc);
        check("t9 latency", 32'(cyc), 32'd3);
        repeat (8) @(negedge clk);
        check("t9 writes", 32'(wr_cnt - wr0), 32'd1);
        check("t9 done", 32'(done_cnt - done0), 32'd1);
        check("t9 pc", 32'(pc), 32'd3);
        check("t9 mem3", 32'(mem[3]), 32'd3);
        check("t9 wr_en idle", 32'(wr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
